axis_packet_arbiter: RTL and testbench

- Shares one downstream AXI-Stream packet buffer (the double-buffered packet store in the pipeline) between NUM_INPUTS AXI-Stream sources.
- Grants whole packets round-robin and tags each forwarded packet's tid with the source index.
- Enforces MAX_PKT_LEN: packets longer than the buffer slot are truncated with a forced tlast, and the remainder is drained.

---
 rtl/axis_packet_arbiter_pkg.sv | 22 ++
 rtl/axis_packet_arbiter_if.sv | 44 ++++
 rtl/axis_packet_arbiter_rr_priority_select.sv | 34 +++
 rtl/axis_packet_arbiter.sv | 136 +++++++++++++
 tb/tb_axis_packet_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and width helpers for the AXI-Stream packet arbiter.
package axis_arb_pkg;

  localparam int unsigned StateWidth = 2;

  typedef enum logic [StateWidth-1:0] {
    StIdle = 2'd0,
    StPass = 2'd1,
    StDrop = 2'd2
  } arb_state_e;

  // Width of a source index; a single source still needs one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the beat counter for a given slot length.
  function automatic int unsigned cnt_width(int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// Bundles the N source streams and the single forwarded stream.
// master: arbiter view (drives the merged stream and the source readies).
// slave:  environment view (drives the sources and the downstream ready).
interface axis_packet_arbiter_if #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TID_WIDTH  = 8
) ();

  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_INPUTS-1:0]            s_axis_tvalid;
  logic [NUM_INPUTS-1:0]            s_axis_tready;
  logic [NUM_INPUTS-1:0]            s_axis_tlast;
  logic [DATA_WIDTH-1:0]            m_axis_tdata;
  logic                             m_axis_tvalid;
  logic                             m_axis_tready;
  logic                             m_axis_tlast;
  logic [TID_WIDTH-1:0]             m_axis_tid;

  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    input  s_axis_tlast,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast,
    output m_axis_tid
  );

  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    output s_axis_tlast,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast,
    input  m_axis_tid
  );

endinterface

// File: rtl/axis_packet_arbiter_rr_priority_select.sv
// Round-robin pick: first set request strictly after the pointer, wrapping.
module rr_priority_select
  import axis_arb_pkg::*;
#(
  parameter int unsigned  NUM_INPUTS = 4,
  localparam int unsigned IdxW       = idx_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [IdxW-1:0]       pointer,
  output logic                  found,
  output logic [IdxW-1:0]       index
);

  logic [2*NUM_INPUTS-1:0] req_dbl;
  logic [2*NUM_INPUTS-1:0] masked;

  // Doubling the request vector turns the wrap-around search into a plain
  // lowest-set-bit search above the pointer.
  always_comb begin
    req_dbl = {req, req};
    masked  = '0;
    for (int j = 0; j < 2 * NUM_INPUTS; j++) begin
      masked[j] = req_dbl[j] && (j > int'(pointer));
    end
    found = |req;
    index = '0;
    for (int j = 2 * NUM_INPUTS - 1; j >= 0; j--) begin
      if (masked[j]) begin
        index = IdxW'(j % NUM_INPUTS);
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Whole-packet round-robin arbiter feeding one downstream packet buffer.
// Packets longer than MAX_PKT_LEN get a forced tlast and the rest is drained.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned  NUM_INPUTS  = 4,
  parameter int unsigned  DATA_WIDTH  = 32,
  parameter int unsigned  TID_WIDTH   = 8,
  parameter int unsigned  MAX_PKT_LEN = 16,
  localparam int unsigned IdxW        = idx_width(NUM_INPUTS)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_packet_arbiter_if.master axis,
  output logic [IdxW-1:0]       grant_idx,
  output logic                  busy,
  output logic                  trunc_pulse
);

  localparam int unsigned        CntW    = cnt_width(MAX_PKT_LEN);
  localparam logic [CntW-1:0]    CntLast = CntW'(MAX_PKT_LEN - 1);
  localparam logic [IdxW-1:0]    PtrInit = IdxW'(NUM_INPUTS - 1);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] grant_q;
  logic [IdxW-1:0] ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            trunc_q;

  logic            sel_found;
  logic [IdxW-1:0] sel_index;
  logic            g_valid;
  logic            g_last;
  logic            at_limit;
  logic            pass_hs;
  logic            drop_hs;

  rr_priority_select #(
    .NUM_INPUTS(NUM_INPUTS)
  ) u_sel (
    .req    (axis.s_axis_tvalid),
    .pointer(ptr_q),
    .found  (sel_found),
    .index  (sel_index)
  );

  // Granted-source handshake terms shared by FSM, counter and outputs.
  always_comb begin
    g_valid  = axis.s_axis_tvalid[grant_q];
    g_last   = axis.s_axis_tlast[grant_q];
    at_limit = (cnt_q == CntLast);
    pass_hs  = (state_q == StPass) && g_valid && axis.m_axis_tready;
    drop_hs  = (state_q == StDrop) && g_valid;
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; source tlast wins over the length limit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) state_d = StPass;
      end
      StPass: begin
        if (pass_hs) begin
          if (g_last)        state_d = StIdle;
          else if (at_limit) state_d = StDrop;
        end
      end
      StDrop: begin
        if (drop_hs && g_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Grant, round-robin pointer, beat counter and truncation pulse.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      grant_q <= '0;
      ptr_q   <= PtrInit;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      trunc_q <= pass_hs && !g_last && at_limit;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (sel_found) begin
            grant_q <= sel_index;
            ptr_q   <= sel_index;
          end
        end
        StPass: begin
          if (pass_hs && !g_last && !at_limit) cnt_q <= cnt_q + CntW'(1);
        end
        default: ;
      endcase
    end
  end

  // Output mux and ready steering; only the granted source ever sees ready.
  always_comb begin
    axis.s_axis_tready = '0;
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tdata  = '0;
    axis.m_axis_tlast  = 1'b0;
    axis.m_axis_tid    = '0;
    unique case (state_q)
      StPass: begin
        axis.m_axis_tvalid          = g_valid;
        axis.m_axis_tdata           = axis.s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        axis.m_axis_tlast           = g_last || at_limit;
        axis.m_axis_tid             = TID_WIDTH'(grant_q);
        axis.s_axis_tready[grant_q] = axis.m_axis_tready;
      end
      StDrop: begin
        axis.s_axis_tready[grant_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant_idx   = grant_q;
  assign busy        = (state_q != StIdle);
  assign trunc_pulse = trunc_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter (4 inputs, 32-bit data, 16-beat slots).
module tb_axis_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [1:0] grant_idx;
  logic       busy;
  logic       trunc_pulse;

  axis_packet_arbiter_if #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .TID_WIDTH(8)) bus ();

  axis_packet_arbiter #(
    .NUM_INPUTS (N),
    .DATA_WIDTH (DW),
    .TID_WIDTH  (8),
    .MAX_PKT_LEN(16)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .axis       (bus),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .trunc_pulse(trunc_pulse)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Source models: packets of src_len beats, src_pkts still to send.
  int src_len[N];
  int src_beat[N];
  int src_pkts[N];
  int src_pktno[N];

  // Values sampled mid-cycle by step().
  logic        c_mvalid, c_mlast, c_busy, c_trunc;
  logic [31:0] c_mdata;
  logic [7:0]  c_tid;
  logic [3:0]  c_sready;
  logic [1:0]  c_grant;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkdata(int src, int pkt, int beat);
    return {8'(src), 8'(pkt), 16'(beat)};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.s_axis_tvalid[i]          = (src_pkts[i] > 0);
      bus.s_axis_tlast[i]           = (src_beat[i] == src_len[i] - 1);
      bus.s_axis_tdata[i*DW +: DW]  = mkdata(i, src_pktno[i], src_beat[i]);
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 1; src_beat[i] = 0; src_pkts[i] = 0; src_pktno[i] = 0;
    end
    drive();
  endtask

  // Sample at negedge, then advance sources on their handshakes after posedge.
  task automatic step();
    logic [3:0] hs;
    @(negedge aclk);
    c_mvalid = bus.m_axis_tvalid;
    c_mlast  = bus.m_axis_tlast;
    c_mdata  = bus.m_axis_tdata;
    c_tid    = bus.m_axis_tid;
    c_sready = bus.s_axis_tready;
    c_busy   = busy;
    c_trunc  = trunc_pulse;
    c_grant  = grant_idx;
    hs       = bus.s_axis_tvalid & bus.s_axis_tready;
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] = 0;
          src_pkts[i]--;
          src_pktno[i]++;
        end else begin
          src_beat[i]++;
        end
      end
    end
    drive();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_sources();
    step();
    step();
    aresetn = 1'b1;
  endtask

  task automatic drain();
    bit done = 0;
    bus.m_axis_tready = 1'b1;
    for (int k = 0; k < 400 && !done; k++) begin
      step();
      if (c_busy == 1'b0 && src_pkts[0] == 0 && src_pkts[1] == 0 &&
          src_pkts[2] == 0 && src_pkts[3] == 0) done = 1;
    end
    check_eq("drain_done", 32'(done), 32'd1);
  endtask

  task automatic check_beat(string tag, int src, int pkt, int beat, logic last);
    check_eq({tag, "_valid"}, 32'(c_mvalid), 32'd1);
    check_eq({tag, "_tid"}, 32'(c_tid), 32'(src));
    check_eq({tag, "_data"}, c_mdata, mkdata(src, pkt, beat));
    check_eq({tag, "_last"}, 32'(c_mlast), 32'(last));
  endtask

  initial begin
    bus.m_axis_tready = 1'b1;
    clear_sources();

    // Reset state.
    do_reset();
    check_eq("rst_busy", 32'(c_busy), 32'd0);
    check_eq("rst_mvalid", 32'(c_mvalid), 32'd0);
    check_eq("rst_sready", 32'(c_sready), 32'd0);
    check_eq("rst_grant", 32'(c_grant), 32'd0);
    check_eq("rst_trunc", 32'(c_trunc), 32'd0);
    check_eq("rst_tid", 32'(c_tid), 32'd0);

    // Inputs 0 and 2, one 3-beat packet each.
    src_len[0] = 3; src_pkts[0] = 1;
    src_len[2] = 3; src_pkts[2] = 1;
    drive();
    step();
    check_eq("s1_bubble0_valid", 32'(c_mvalid), 32'd0);
    check_eq("s1_bubble0_busy", 32'(c_busy), 32'd0);
    for (int b = 0; b < 3; b++) begin
      step();
      check_beat("s1_src0", 0, 0, b, b == 2);
    end
    step();
    check_eq("s1_bubble1_valid", 32'(c_mvalid), 32'd0);
    check_eq("s1_bubble1_busy", 32'(c_busy), 32'd0);
    for (int b = 0; b < 3; b++) begin
      step();
      check_beat("s1_src2", 2, 0, b, b == 2);
    end
    step();
    check_eq("s1_end_busy", 32'(c_busy), 32'd0);

    // All four inputs valid, single-beat packets: 0,1,2,3,0,1 with bubbles.
    do_reset();
    for (int i = 0; i < N; i++) src_pkts[i] = 2;
    drive();
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("s2_bubble", 32'(c_mvalid), 32'd0);
      step();
      check_beat("s2_rr", k % 4, k / 4, 0, 1'b1);
    end
    drain();

    // Input 1 sends 20 beats: 16 forwarded, forced tlast, 4 drained.
    do_reset();
    src_len[1] = 20; src_pkts[1] = 1;
    drive();
    step();
    check_eq("s3_bubble", 32'(c_mvalid), 32'd0);
    for (int b = 0; b < 16; b++) begin
      step();
      check_beat("s3_pass", 1, 0, b, b == 15);
      check_eq("s3_pass_trunc", 32'(c_trunc), 32'd0);
    end
    for (int b = 16; b < 20; b++) begin
      step();
      check_eq("s3_drop_valid", 32'(c_mvalid), 32'd0);
      check_eq("s3_drop_sready", 32'(c_sready), 32'h2);
      check_eq("s3_drop_busy", 32'(c_busy), 32'd1);
      check_eq("s3_drop_trunc", 32'(c_trunc), (b == 16) ? 32'd1 : 32'd0);
    end
    step();
    check_eq("s3_idle_busy", 32'(c_busy), 32'd0);
    check_eq("s3_src_done", 32'(src_pkts[1]), 32'd0);

    // Exactly 16 beats on input 2: no truncation, straight back to idle.
    src_len[2] = 16; src_pkts[2] = 1;
    drive();
    step();
    check_eq("s4_bubble", 32'(c_mvalid), 32'd0);
    for (int b = 0; b < 16; b++) begin
      step();
      check_beat("s4_pass", 2, 0, b, b == 15);
      check_eq("s4_trunc", 32'(c_trunc), 32'd0);
    end
    step();
    check_eq("s4_after_busy", 32'(c_busy), 32'd0);
    check_eq("s4_after_trunc", 32'(c_trunc), 32'd0);
    check_eq("s4_after_valid", 32'(c_mvalid), 32'd0);

    // Toggling downstream ready on a 4-beat packet from input 0; input 1 waits.
    src_len[0] = 4; src_pkts[0] = 1;
    src_len[1] = 1; src_pkts[1] = 1;
    drive();
    step();
    check_eq("s5_bubble", 32'(c_mvalid), 32'd0);
    begin
      int exp_beat[7] = '{0, 1, 1, 2, 2, 3, 3};
      for (int k = 0; k < 7; k++) begin
        logic rdy;
        rdy = (k % 2 == 0);
        bus.m_axis_tready = rdy;
        step();
        check_beat("s5_tog", 0, 0, exp_beat[k], exp_beat[k] == 3);
        check_eq("s5_sready", 32'(c_sready), 32'(rdy));
      end
    end
    bus.m_axis_tready = 1'b1;
    step();
    check_eq("s5_idle_busy", 32'(c_busy), 32'd0);
    drain();

    // Reset at beat 2 of a packet on input 3, then inputs 0 and 3 compete.
    do_reset();
    src_len[3] = 6; src_pkts[3] = 1;
    drive();
    step();
    step();
    check_beat("s6_b0", 3, 0, 0, 1'b0);
    step();
    check_beat("s6_b1", 3, 0, 1, 1'b0);
    aresetn = 1'b0;
    src_len[0] = 1; src_pkts[0] = 1;
    drive();
    step();
    check_beat("s6_b2", 3, 0, 2, 1'b0);
    aresetn = 1'b1;
    step();
    check_eq("s6_rst_valid", 32'(c_mvalid), 32'd0);
    check_eq("s6_rst_busy", 32'(c_busy), 32'd0);
    check_eq("s6_rst_sready", 32'(c_sready), 32'd0);
    check_eq("s6_rst_grant", 32'(c_grant), 32'd0);
    step();
    check_eq("s6_regrant", 32'(c_grant), 32'd0);
    check_beat("s6_src0", 0, 0, 0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
